// File: rtl/sm_control_param.sv
// Shift-and-add multiplier controller: a Moore FSM that sequences the datapath
// strobes for one multiply, walking the multiplier one bit per TEST/ADD/SHIFT pass.
module sm_control_param #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] mr_i,
  output logic             mdld_o,
  output logic             mrld_o,
  output logic             rsclear_o,
  output logic             rsload_o,
  output logic             rsshr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bitidx_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (start_i) state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        state_d = TEST;
      end
      TEST:  state_d = mr_i[cnt_q] ? ADD : SHIFT;
      ADD:   state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = TEST;
        end
      end
      DONE:  state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort wins over every transition once an operation has begun.
    if (state_q != IDLE && abort_i) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
    end
  end

  assign mdld_o    = (state_q == LOAD);
  assign mrld_o    = (state_q == LOAD);
  assign rsclear_o = (state_q == LOAD);
  assign rsload_o  = (state_q == ADD);
  assign rsshr_o   = (state_q == SHIFT);
  assign done_o    = (state_q == DONE);
  assign busy_o    = (state_q != IDLE);
  assign bitidx_o  = cnt_q;

endmodule

// File: doc/sm_control_param.md
SM_CONTROL_PARAM -- requirements
Module: sm_control_param

Interface
REQ-001 Parameter: WIDTH, 4, multiplier/multiplicand width in bits; legal range 2..32.
REQ-002 Localparam CNT_W = $clog2(WIDTH); width of the bit counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  begin a multiply; sampled only in IDLE.
REQ-006 abort  input  1  cancel the operation in progress; sampled in every non-IDLE state.
REQ-007 mr  input  WIDTH  multiplier register contents from the datapath.
REQ-008 mdld  output  1  load multiplicand register.
REQ-009 mrld  output  1  load multiplier register.
REQ-010 rsclear  output  1  clear running-sum register.
REQ-011 rsload  output  1  load running-sum register with the adder result.
REQ-012 rsshr  output  1  shift running-sum register right one bit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 bitidx  output  CNT_W  index of the multiplier bit currently under test.

Function
REQ-016 Moore FSM; all outputs decode from the registered state and counter only; no output depends combinationally on any input.
REQ-017 States: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
REQ-018 Only one of mdld/mrld/rsclear group, rsload, rsshr, done is active in any cycle; all default 0.
REQ-019 IDLE: all strobes 0; start=1 -> LOAD; otherwise stay.
REQ-020 LOAD: mdld=mrld=rsclear=1; bitidx cleared to 0; -> TEST.
REQ-021 TEST: no strobes; mr[bitidx]=1 -> ADD, else -> SHIFT.
REQ-022 ADD: rsload=1; -> SHIFT.
REQ-023 SHIFT: rsshr=1; if bitidx==WIDTH-1 -> DONE, else bitidx increments by 1 and -> TEST.
REQ-024 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-025 bitidx holds its value in all states other than LOAD and SHIFT; it never exceeds WIDTH-1 and never wraps.
REQ-026 Latency: start sampled high in IDLE -> done high exactly 2 + 2*WIDTH + popcount(mr) cycles later.
REQ-027 start while busy is ignored; start held high continuously re-launches immediately after DONE->IDLE (IDLE lasts one cycle).
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle; no further strobes; done is not asserted.
REQ-029 abort in DONE: done still pulses that cycle; the next state is IDLE.
REQ-030 abort and start both high in IDLE: abort is ignored; start is accepted.
REQ-031 mr is sampled in TEST only; changes to mr in other states have no effect.

Reset
REQ-032 rst=1 at a clock edge -> state IDLE, bitidx=0, all outputs 0 on the following cycle; rst overrides start and abort.
REQ-033 rst mid-operation discards the operation; done is not asserted.

Verification
REQ-034 WIDTH=4, mr=4'b1011, start pulse -> LOAD, T,A,S, T,A,S, T,S, T,A,S, DONE; done 13 cycles after start; rsload x3; rsshr x4.
REQ-035 WIDTH=4, mr=4'b0000 -> rsload never asserted; rsshr x4; done 10 cycles after start.
REQ-036 WIDTH=8, mr=8'hFF -> rsload x8; rsshr x8; done 26 cycles after start; bitidx sequence 0..7.
REQ-037 WIDTH=4, abort in the 2nd TEST -> IDLE next cycle; no done; busy low; a new start then runs normally.
REQ-038 start held high for 30 cycles with WIDTH=4, mr=4'b0001 -> back-to-back operations; done every 12 cycles; no start accepted while busy.
REQ-039 rst asserted during ADD -> all outputs 0 and bitidx=0 next cycle; done never pulses for the aborted operation.
